// File: rtl/debug_cmd_sync_queue.sv
// System-clock half of the CPU debug slave: synchronises TCK update strobes and queues IR/SR snapshots.
// Optional update-IR capture path is enabled by defining DEBUG_CMD_UIR_EN.
module debug_cmd_sync_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DATA_W-1:0]        sr,
  input  logic                     cmd_ready,
  input  logic                     ovf_clr,
  output logic                     cmd_valid,
  output logic [DATA_W-1:0]        cmd_data,
  output logic [IR_W-1:0]          cmd_ir,
  output logic                     cmd_kind,
  output logic [(2**IR_W)-1:0]     cmd_sel,
  output logic                     cmd_action,
  output logic                     cmd_no_action,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int SEL_W = 2**IR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 1 + IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] udr_sync_reg;
  logic                   udr_hist_reg;
  logic                   udr_evt;
  logic                   uir_evt;
  logic                   push_kind;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_reg <= '0;
      udr_hist_reg <= 1'b0;
    end else begin
      udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
      udr_hist_reg <= udr_sync_reg[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synced level: a strobe held high yields a single event.
  assign udr_evt = udr_sync_reg[SYNC_STAGES-1] & ~udr_hist_reg;

`ifdef DEBUG_CMD_UIR_EN
  logic [SYNC_STAGES-1:0] uir_sync_reg;
  logic                   uir_hist_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_reg <= '0;
      uir_hist_reg <= 1'b0;
    end else begin
      uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
      uir_hist_reg <= uir_sync_reg[SYNC_STAGES-1];
    end
  end

  assign uir_evt   = uir_sync_reg[SYNC_STAGES-1] & ~uir_hist_reg;
  assign push_kind = ~udr_evt;
`else
  logic unused_uir;
  assign unused_uir = vs_uir;
  assign uir_evt    = 1'b0;
  assign push_kind  = 1'b0;
`endif

  logic [ENT_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             ovf_reg;

  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             drop;
  logic [ENT_W-1:0] wr_entry;

  assign push_req = udr_evt | uir_evt;
  assign full     = (level_reg == LVL_W'(DEPTH));
  assign pop      = cmd_valid & cmd_ready;
  // A simultaneous pop frees the slot, so a push into a full queue still lands.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = (push_req & full & ~pop) | (udr_evt & uir_evt);
  // ir_in and sr are quasi-static around update-DR, so they are sampled without synchronisation.
  assign wr_entry = {push_kind, ir_in, (udr_evt ? sr : {DATA_W{1'b0}})};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push_ok) - LVL_W'(pop);
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_entry;
  end

  logic [ENT_W-1:0]  head;
  logic              head_kind;
  logic [IR_W-1:0]   head_ir;
  logic [DATA_W-1:0] head_data;

  assign head      = mem_reg[rd_ptr_reg];
  assign head_kind = head[ENT_W-1];
  assign head_ir   = head[DATA_W +: IR_W];
  assign head_data = head[DATA_W-1:0];

  // Outputs come only from registered state and are forced to zero when empty.
  assign cmd_valid     = (level_reg != '0);
  assign cmd_data      = cmd_valid ? head_data : '0;
  assign cmd_ir        = cmd_valid ? head_ir : '0;
  assign cmd_kind      = cmd_valid & head_kind;
  assign cmd_action    = cmd_valid & ~head_kind & head_data[DATA_W-1];
  assign cmd_no_action = cmd_valid & ~head_kind & ~head_data[DATA_W-1];
  assign fifo_level    = level_reg;
  assign overflow      = ovf_reg;

  generate
    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_sel
      assign cmd_sel[gi] = cmd_valid & (head_ir == IR_W'(gi));
    end
  endgenerate

endmodule
